btn_conditioner: RTL and testbench

// - Upstream stage of the LED/7-seg LFSR shifter: turns a raw, bouncy board button into clean single-cycle

---
 rtl/btn_conditioner_if.sv | 22 ++
 rtl/btn_conditioner.sv | 138 +++++++++++++
 tb/tb_btn_conditioner.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw button in, debounced level/strobes/count out.
// The outputs are free-running strobes with no valid/ready backpressure. A consumer samples them on the same clock.
interface btn_conditioner_if;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       step_pulse;
  logic       long_press;
  logic [7:0] press_count;
  logic [2:0] state;

  modport master (
    output btn_raw,
    input  btn_level, press_pulse, release_pulse, step_pulse, long_press, press_count, state
  );

  modport slave (
    input  btn_raw,
    output btn_level, press_pulse, release_pulse, step_pulse, long_press, press_count, state
  );
endinterface

// File: rtl/btn_conditioner.sv
// Turns a raw, bouncy button into clean single-cycle strobes: 2-FF synchroniser, debounce FSM,
// auto-repeat while held, and a wrapping press counter. All outputs are registered.
module btn_conditioner #(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 0
) (
  input logic              clk,
  input logic              rst_n,
  btn_conditioner_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } state_t;

  localparam logic             IDLE_LVL    = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             step_q;
  logic             long_q;
  logic [7:0]       count_q;
  logic             btn_s;

  // Synchroniser resets to the electrical "not pressed" level, so btn_s starts at 0.
  assign btn_s = sync_q[1] ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {2{IDLE_LVL}};
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync_q    <= {sync_q[0], bus.btn_raw};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= DB_PRESS;
            cnt_q   <= '0;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state_q <= IDLE;
          end else if (cnt_q == DB_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            step_q  <= 1'b1;
            level_q <= 1'b1;
            count_q <= count_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= DB_RELEASE;
            cnt_q   <= '0;
          end else if (cnt_q == DELAY_LAST) begin
            // Without auto-repeat the counter parks here until release.
            if (REPEAT_EN != 0) begin
              state_q <= REPEAT;
              cnt_q   <= '0;
              step_q  <= 1'b1;
              long_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!btn_s) begin
            state_q <= DB_RELEASE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
          end else if (cnt_q == PERIOD_LAST) begin
            step_q <= 1'b1;
            cnt_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DB_RELEASE: begin
          // A glitch back to pressed returns to HELD and restarts the repeat delay.
          if (btn_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.step_pulse    = step_q;
  assign bus.long_press    = long_q;
  assign bus.press_count   = count_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: three instances (repeat on, repeat off, active-low input) checked every
// cycle against a run-length reference model, plus directed checks of the documented scenarios.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk;
  logic rst_n;
  logic raw;

  int checks;
  int errors;

  btn_conditioner_if bus0 ();
  btn_conditioner_if bus1 ();
  btn_conditioner_if bus2 ();

  assign bus0.btn_raw = raw;
  assign bus1.btn_raw = raw;
  assign bus2.btn_raw = ~raw;

  btn_conditioner #(.CNT_W(20), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                    .REPEAT_EN(1), .ACTIVE_LOW(0)) u_rep (.clk(clk), .rst_n(rst_n), .bus(bus0));
  btn_conditioner #(.CNT_W(20), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                    .REPEAT_EN(0), .ACTIVE_LOW(0)) u_norep (.clk(clk), .rst_n(rst_n), .bus(bus1));
  btn_conditioner #(.CNT_W(20), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                    .REPEAT_EN(1), .ACTIVE_LOW(1)) u_alow (.clk(clk), .rst_n(rst_n), .bus(bus2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: model 0 has auto-repeat, model 1 does not
  logic       d1, d2;
  int         run_n[2];
  int         hold_n[2];
  logic       e_level[2], e_press[2], e_rel[2], e_step[2], e_long[2];
  logic [7:0] e_cnt[2];

  task automatic model_reset();
    d1 = 1'b0;
    d2 = 1'b0;
    for (int m = 0; m < 2; m++) begin
      run_n[m] = 0; hold_n[m] = 0;
      e_level[m] = 1'b0; e_press[m] = 1'b0; e_rel[m] = 1'b0;
      e_step[m] = 1'b0; e_long[m] = 1'b0; e_cnt[m] = 8'd0;
    end
  endtask

  // One clock edge: accept a level change after DB+1 consecutive opposite samples; while pressed,
  // count held samples since acceptance (or since a rejected release glitch) to place repeat steps.
  task automatic model_step();
    logic s;
    s  = d2;
    d2 = d1;
    d1 = raw;
    for (int m = 0; m < 2; m++) begin
      e_press[m] = 1'b0; e_rel[m] = 1'b0; e_step[m] = 1'b0;
      if (!e_level[m]) begin
        run_n[m] = s ? run_n[m] + 1 : 0;
        if (run_n[m] == DB + 1) begin
          e_level[m] = 1'b1; e_press[m] = 1'b1; e_step[m] = 1'b1;
          e_cnt[m] = e_cnt[m] + 8'd1;
          run_n[m] = 0; hold_n[m] = 0;
        end
      end else if (s) begin
        hold_n[m] = (run_n[m] > 0) ? 0 : hold_n[m] + 1;
        run_n[m] = 0;
        if (m == 0 && (hold_n[m] == RD || (hold_n[m] > RD && (hold_n[m] - RD) % RP == 0)))
          e_step[m] = 1'b1;
      end else begin
        run_n[m] = run_n[m] + 1;
        if (run_n[m] == DB + 1) begin
          e_level[m] = 1'b0; e_rel[m] = 1'b1; run_n[m] = 0;
        end
      end
      e_long[m] = (m == 0) && e_level[m] && s && (hold_n[m] >= RD);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_dut(input string nm, input logic [12:0] obs, input int m);
    chk({nm, ".btn_level"},     {7'd0, obs[12]}, {7'd0, e_level[m]});
    chk({nm, ".press_pulse"},   {7'd0, obs[11]}, {7'd0, e_press[m]});
    chk({nm, ".release_pulse"}, {7'd0, obs[10]}, {7'd0, e_rel[m]});
    chk({nm, ".step_pulse"},    {7'd0, obs[9]},  {7'd0, e_step[m]});
    chk({nm, ".long_press"},    {7'd0, obs[8]},  {7'd0, e_long[m]});
    chk({nm, ".press_count"},   obs[7:0],        e_cnt[m]);
  endtask

  function automatic logic [12:0] pack0();
    return {bus0.btn_level, bus0.press_pulse, bus0.release_pulse, bus0.step_pulse,
            bus0.long_press, bus0.press_count};
  endfunction
  function automatic logic [12:0] pack1();
    return {bus1.btn_level, bus1.press_pulse, bus1.release_pulse, bus1.step_pulse,
            bus1.long_press, bus1.press_count};
  endfunction
  function automatic logic [12:0] pack2();
    return {bus2.btn_level, bus2.press_pulse, bus2.release_pulse, bus2.step_pulse,
            bus2.long_press, bus2.press_count};
  endfunction

  task automatic check_all();
    chk_dut("rep", pack0(), 0);
    chk_dut("norep", pack1(), 1);
    chk_dut("alow", pack2(), 0);
  endtask

  // driver: present raw level, take one edge, update model, compare 1 time unit later
  task automatic tick(input logic r);
    raw = r;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n_step0, n_step1, n_rel, n_pulse;

  initial begin
    checks = 0;
    errors = 0;
    raw    = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_state_idle", {5'd0, bus0.state}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean press held 8 cycles: strobes after edge 7
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      if (i == 6) chk("no_press_before_edge7", {7'd0, bus0.press_pulse}, 8'd0);
      if (i == 7) begin
        chk("press_at_edge7", {7'd0, bus0.press_pulse}, 8'd1);
        chk("step_at_edge7", {7'd0, bus0.step_pulse}, 8'd1);
      end
    end
    chk("count_after_first_press", bus0.press_count, 8'd1);

    // long hold from a fresh reset: repeat-on gives 9 steps over 40 edges, repeat-off exactly one
    do_reset();
    n_step0 = 0;
    n_step1 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1);
      n_step0 += int'(bus0.step_pulse);
      n_step1 += int'(bus1.step_pulse);
      if (i == 16) chk("long_low_before_repeat", {7'd0, bus0.long_press}, 8'd0);
      if (i == 17) chk("long_high_first_repeat", {7'd0, bus0.long_press}, 8'd1);
    end
    chk("repeat_step_total", n_step0[7:0], 8'd9);
    chk("norepeat_single_step", n_step1[7:0], 8'd1);

    // release, 1-cycle glitch during release debounce, then stable low
    n_rel = 0;
    repeat (3) begin tick(1'b0); n_rel += int'(bus0.release_pulse); end
    tick(1'b1);
    n_rel += int'(bus0.release_pulse);
    repeat (4) begin tick(1'b0); n_rel += int'(bus0.release_pulse); end
    chk("glitch_no_release", n_rel[7:0], 8'd0);
    chk("glitch_level_held", {7'd0, bus0.btn_level}, 8'd1);
    repeat (8) begin tick(1'b0); n_rel += int'(bus0.release_pulse); end
    chk("single_release_after_glitch", n_rel[7:0], 8'd1);

    // reset mid-REPEAT with the button still held
    repeat (25) tick(1'b1);
    chk("in_repeat_before_reset", {7'd0, bus0.long_press}, 8'd1);
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      if (i == 7) chk("press_after_reset_edge7", {7'd0, bus0.press_pulse}, 8'd1);
    end
    chk("count_after_reset_press", bus0.press_count, 8'd1);
    repeat (10) tick(1'b0);

    // bounce shorter than the debounce window
    n_pulse = 0;
    repeat (2) begin tick(1'b1); n_pulse += int'(bus0.press_pulse | bus0.release_pulse | bus0.step_pulse); end
    repeat (1) begin tick(1'b0); n_pulse += int'(bus0.press_pulse | bus0.release_pulse | bus0.step_pulse); end
    repeat (3) begin tick(1'b1); n_pulse += int'(bus0.press_pulse | bus0.release_pulse | bus0.step_pulse); end
    repeat (8) begin tick(1'b0); n_pulse += int'(bus0.press_pulse | bus0.release_pulse | bus0.step_pulse); end
    chk("bounce_no_pulses", n_pulse[7:0], 8'd0);
    chk("bounce_level_low", {7'd0, bus0.btn_level}, 8'd0);
    chk("bounce_back_idle", {5'd0, bus0.state}, 8'd0);

    // 256 clean presses wrap the counter
    do_reset();
    repeat (256) begin
      repeat (6) tick(1'b1);
      repeat (6) tick(1'b0);
    end
    chk("count_wraps_to_zero", bus0.press_count, 8'd0);

    // randomized runs with occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      logic r;
      int   len;
      r   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 18);
      repeat (len) tick(r);
      if ($urandom_range(0, 24) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
